shift_cmd_queue: RTL and testbench

Buffered command front-end for the combinational barrel shifter. It accepts shift commands (data, amount, direction, mode) over a valid/ready handshake and stores them in a DEPTH-entry FIFO. It presents the head command to the shifter and captures the shifter result into a registered valid/ready output stage. Out-of-range shift amounts are flagged and passed through unchanged, with a saturating error count.

---
 rtl/shift_cmd_queue.sv | 170 +++++++++++++++++
 tb/tb_shift_cmd_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: buffered command front-end for an external combinational
// barrel shifter. Commands enter a DEPTH-entry FIFO, the head command is
// presented on Sh_*, and the shifter result is captured into a registered
// valid/ready output stage. Illegal shift amounts (>7) bypass the shifter,
// are flagged on Out_err and counted in a saturating error counter.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge.
// The consumer may change ready at any time. In_ready depends only on
// registered occupancy, so it never combinationally depends on In_valid.
module shift_cmd_queue #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // command input
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [DATA_W-1:0] In_data,
  input  logic [3:0]        In_shift,
  input  logic              In_dir,
  input  logic              In_mode,
  // head command to the shifter
  output logic [DATA_W-1:0] Sh_A,
  output logic [3:0]        Sh_shift,
  output logic              Sh_dir,
  output logic              Sh_mode,
  input  logic [DATA_W-1:0] Sh_result,
  // result output stage
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Out_data,
  output logic              Out_err,
  // status
  output logic [CNT_W-1:0]  Count,
  output logic [7:0]        Err_count
);

  // FIFO storage, one field array per command field
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [3:0]        shift_q [DEPTH];
  logic              dir_q   [DEPTH];
  logic              mode_q  [DEPTH];
  logic              err_q   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              full;
  logic              head_valid;
  logic              head_err;
  logic              push;
  logic              load;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head_err   = err_q[rd_ptr_q];

  // A full queue never accepts, so push and load on a full queue cannot coincide.
  assign push = In_valid && !full;
  // Load whenever a command is waiting and the output register is free or draining.
  assign load = head_valid && (!out_valid_q || Out_ready);

  // Head command mux; forced to zero while the queue is empty.
  always_comb begin
    Sh_A     = '0;
    Sh_shift = '0;
    Sh_dir   = 1'b0;
    Sh_mode  = 1'b0;
    if (head_valid) begin
      Sh_A     = data_q[rd_ptr_q];
      Sh_shift = shift_q[rd_ptr_q];
      Sh_dir   = dir_q[rd_ptr_q];
      Sh_mode  = mode_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy, output stage and error counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (load) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, load})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (load) begin
      // Illegal amounts pass the operand through untouched.
      out_data_d  = head_err ? data_q[rd_ptr_q] : Sh_result;
      out_err_d   = head_err;
      out_valid_d = 1'b1;
      if (head_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (Out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // FIFO storage write on push; cleared on reset so no stale command survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        shift_q[i] <= '0;
        dir_q[i]   <= 1'b0;
        mode_q[i]  <= 1'b0;
        err_q[i]   <= 1'b0;
      end
    end else if (push) begin
      data_q[wr_ptr_q]  <= In_data;
      shift_q[wr_ptr_q] <= In_shift;
      dir_q[wr_ptr_q]   <= In_dir;
      mode_q[wr_ptr_q]  <= In_mode;
      err_q[wr_ptr_q]   <= (In_shift > 4'd7);
    end
  end

  assign In_ready  = !full;
  assign Out_valid = out_valid_q;
  assign Out_data  = out_data_q;
  assign Out_err   = out_err_q;
  assign Count     = count_q;
  assign Err_count = err_cnt_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed testbench for shift_cmd_queue with a behavioural barrel shifter
// attached to the Sh_* port and hand-computed expected results.
module tb_shift_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       In_valid;
  logic       In_ready;
  logic [7:0] In_data;
  logic [3:0] In_shift;
  logic       In_dir;
  logic       In_mode;
  logic [7:0] Sh_A;
  logic [3:0] Sh_shift;
  logic       Sh_dir;
  logic       Sh_mode;
  logic [7:0] Sh_result;
  logic       Out_valid;
  logic       Out_ready;
  logic [7:0] Out_data;
  logic       Out_err;
  logic [2:0] Count;
  logic [7:0] Err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_err_q[$];

  shift_cmd_queue #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_data   (In_data),
    .In_shift  (In_shift),
    .In_dir    (In_dir),
    .In_mode   (In_mode),
    .Sh_A      (Sh_A),
    .Sh_shift  (Sh_shift),
    .Sh_dir    (Sh_dir),
    .Sh_mode   (Sh_mode),
    .Sh_result (Sh_result),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_data  (Out_data),
    .Out_err   (Out_err),
    .Count     (Count),
    .Err_count (Err_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural combinational barrel shifter
  always_comb begin
    if (!Sh_dir)      Sh_result = Sh_A << Sh_shift;
    else if (Sh_mode) Sh_result = $signed(Sh_A) >>> Sh_shift;
    else              Sh_result = Sh_A >> Sh_shift;
  end

  // absolute time limit so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] d, input logic [3:0] s,
                           input logic dir, input logic mode);
    In_valid = 1'b1;
    In_data  = d;
    In_shift = s;
    In_dir   = dir;
    In_mode  = mode;
  endtask

  task automatic idle_in();
    In_valid = 1'b0;
    In_data  = '0;
    In_shift = '0;
    In_dir   = 1'b0;
    In_mode  = 1'b0;
  endtask

  // pointer-wrap command table with hand-computed results
  logic [7:0] w_data [10] = '{8'h01, 8'h01, 8'h80, 8'h80, 8'h3C, 8'h7E, 8'hAA, 8'h96, 8'h96, 8'h55};
  logic [3:0] w_shift[10] = '{4'd0,  4'd7,  4'd7,  4'd7,  4'd1,  4'd1,  4'd8,  4'd4,  4'd4,  4'd15};
  logic       w_dir  [10] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
  logic       w_mode [10] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
  logic [7:0] w_exp  [10] = '{8'h01, 8'h80, 8'h01, 8'hFF, 8'h78, 8'h3F, 8'hAA, 8'hF9, 8'h09, 8'h55};
  logic       w_err  [10] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};

  initial begin
    int idx;
    int got;
    int cycles;
    int n_res;
    logic [7:0] e_data;
    logic       e_err;

    rst_n     = 1'b0;
    Out_ready = 1'b0;
    idle_in();

    // ---- reset state ----
    #12;
    check("rst_count",     Count,     0);
    check("rst_out_valid", Out_valid, 0);
    check("rst_out_data",  Out_data,  0);
    check("rst_out_err",   Out_err,   0);
    check("rst_err_count", Err_count, 0);
    check("rst_in_ready",  In_ready,  1);
    check("rst_sh_a",      Sh_A,      0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- left shift, latency ----
    Out_ready = 1'b1;
    drive_cmd(8'h81, 4'd1, 1'b0, 1'b0);
    tick();
    idle_in();
    check("lsl_count_after_push", Count, 1);
    check("lsl_sh_a",             Sh_A, 8'h81);
    check("lsl_sh_shift",         Sh_shift, 1);
    check("lsl_valid_early",      Out_valid, 0);
    tick();
    check("lsl_valid", Out_valid, 1);
    check("lsl_data",  Out_data,  8'h02);
    check("lsl_err",   Out_err,   0);
    check("lsl_empty_sh_a", Sh_A, 0);
    tick();
    check("lsl_valid_falls", Out_valid, 0);

    // ---- right logical / arithmetic back-to-back ----
    drive_cmd(8'hB4, 4'd2, 1'b1, 1'b0);
    tick();
    drive_cmd(8'hB4, 4'd2, 1'b1, 1'b1);
    tick();
    idle_in();
    check("lsr_valid", Out_valid, 1);
    check("lsr_data",  Out_data,  8'h2D);
    tick();
    check("asr_valid", Out_valid, 1);
    check("asr_data",  Out_data,  8'hED);
    tick();
    check("asr_valid_falls", Out_valid, 0);

    // ---- illegal amount, then saturating error count ----
    drive_cmd(8'h5A, 4'd9, 1'b0, 1'b0);
    tick();
    idle_in();
    tick();
    check("ill_valid",     Out_valid, 1);
    check("ill_data",      Out_data,  8'h5A);
    check("ill_err",       Out_err,   1);
    check("ill_err_count", Err_count, 1);
    drive_cmd(8'h5A, 4'd9, 1'b0, 1'b0);
    for (int i = 0; i < 299; i++) tick();
    idle_in();
    tick();
    check("sat_err_flag",  Out_err,   1);
    check("sat_err_count", Err_count, 8'hFF);
    tick();
    check("sat_valid_falls", Out_valid, 0);

    // ---- fill under backpressure ----
    Out_ready = 1'b0;
    drive_cmd(8'h11, 4'd1, 1'b0, 1'b0); tick();
    drive_cmd(8'h80, 4'd3, 1'b1, 1'b0); tick();
    drive_cmd(8'h80, 4'd3, 1'b1, 1'b1); tick();
    drive_cmd(8'h0F, 4'd2, 1'b0, 1'b0); tick();
    drive_cmd(8'hC3, 4'd7, 1'b1, 1'b1); tick();
    check("fill_count",    Count,     DEPTH);
    check("fill_in_ready", In_ready,  0);
    check("fill_valid",    Out_valid, 1);
    check("fill_hold",     Out_data,  8'h22);
    drive_cmd(8'hFF, 4'd0, 1'b0, 1'b0);
    tick();
    idle_in();
    check("fill_reject_count", Count,    DEPTH);
    check("fill_hold_again",   Out_data, 8'h22);
    Out_ready = 1'b1;
    tick();
    check("drain1_data",     Out_data, 8'h10);
    check("drain1_in_ready", In_ready, 1);
    check("drain1_count",    Count,    3);
    tick();
    check("drain2_data", Out_data, 8'hF0);
    tick();
    check("drain3_data", Out_data, 8'h3C);
    tick();
    check("drain4_data",  Out_data,  8'hFF);
    check("drain4_valid", Out_valid, 1);
    check("drain4_count", Count,     0);
    tick();
    check("drain_valid_falls", Out_valid, 0);

    // ---- pointer wrap with random Out_ready ----
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(w_exp[i]);
      exp_err_q.push_back(w_err[i]);
    end
    idx = 0;
    got = 0;
    cycles = 0;
    while ((got < 10) && (cycles < 300)) begin
      if (idx < 10) drive_cmd(w_data[idx], w_shift[idx], w_dir[idx], w_mode[idx]);
      else idle_in();
      Out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (Out_valid && Out_ready) begin
        if (exp_q.size() == 0) begin
          check("wrap_extra_result", 1, 0);
        end else begin
          e_data = exp_q.pop_front();
          e_err  = exp_err_q.pop_front();
          check("wrap_data", Out_data, e_data);
          check("wrap_err",  Out_err,  e_err);
        end
        got++;
      end
      if (In_valid && In_ready) idx++;
      tick();
      cycles++;
    end
    idle_in();
    check("wrap_all_results", got, 10);
    check("wrap_queue_empty", exp_q.size(), 0);
    Out_ready = 1'b1;
    tick();
    check("wrap_count_end", Count, 0);
    check("wrap_err_count_held", Err_count, 8'hFF);

    // ---- reset mid-stream ----
    Out_ready = 1'b0;
    drive_cmd(8'h01, 4'd1, 1'b0, 1'b0); tick();
    drive_cmd(8'h02, 4'd1, 1'b0, 1'b0); tick();
    drive_cmd(8'h03, 4'd1, 1'b0, 1'b0); tick();
    drive_cmd(8'h04, 4'd1, 1'b0, 1'b0); tick();
    idle_in();
    check("mid_count", Count,     3);
    check("mid_valid", Out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_count",     Count,     0);
    check("mrst_valid",     Out_valid, 0);
    check("mrst_data",      Out_data,  0);
    check("mrst_err",       Out_err,   0);
    check("mrst_err_count", Err_count, 0);
    check("mrst_in_ready",  In_ready,  1);
    check("mrst_sh_a",      Sh_A,      0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    Out_ready = 1'b1;
    drive_cmd(8'h21, 4'd2, 1'b0, 1'b0);
    tick();
    idle_in();
    n_res = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (Out_valid && Out_ready) begin
        n_res++;
        check("post_rst_data", Out_data, 8'h84);
      end
      tick();
    end
    check("post_rst_one_result", n_res, 1);
    check("post_rst_count",      Count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
